circuit_2_sched: RTL

//  Multicycle scheduler that evaluates the circuit_2 dataflow using ONE shared
//  add/sub unit and one comparator instead of three parallel arithmetic units.

---
 rtl/circuit_2_sched.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/circuit_2_sched.sv
// circuit_2_sched: multicycle evaluation of the circuit_2 dataflow.
// One shared add/sub unit and one comparator are time-multiplexed over
// six states. Operands a/b/c are captured when a start request is accepted;
// x/z are registered when the DONE state is entered.
// Optional feature macro: SCHED_OVF_EN (sticky carry/borrow flag on ovf).
module circuit_2_sched #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] x,
    output logic [DATAWIDTH-1:0] z,
    output logic                 ovf
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADD_AB  = 3'd1,
        S_ADD_AC  = 3'd2,
        S_SUB_AB  = 3'd3,
        S_CMP_SEL = 3'd4,
        S_SHIFT   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic [DATAWIDTH-1:0] d_q, d_d, e_q, e_d, f_q, f_d;
    logic [DATAWIDTH-1:0] g_q, g_d, h_q, h_d;
    logic                 dlte_q, dlte_d, deq_q, deq_d;
    logic [DATAWIDTH-1:0] x_q, x_d, z_q, z_d;
    logic                 busy_q, busy_d, done_q, done_d;

    // Shared arithmetic unit operand select and carry-in
    logic [DATAWIDTH-1:0] op_b_s;
    logic                 cin_s;
    logic [DATAWIDTH-1:0] sum_s;

    // Comparator results (always looking at d and e)
    logic                 cmp_lt_s;
    logic                 cmp_eq_s;

`ifdef SCHED_OVF_EN
    logic                 ovf_q, ovf_d;
    logic [DATAWIDTH:0]   sum_ext_s;
    logic                 carry_s;
`endif

    // Second operand of the shared unit is chosen purely by the state
    always_comb begin
        op_b_s = rb_q;
        cin_s  = 1'b0;
        case (state_q)
            S_ADD_AB: begin
                op_b_s = rb_q;
                cin_s  = 1'b0;
            end
            S_ADD_AC: begin
                op_b_s = rc_q;
                cin_s  = 1'b0;
            end
            S_SUB_AB: begin
                op_b_s = ~rb_q;
                cin_s  = 1'b1;
            end
            default: begin
                op_b_s = rb_q;
                cin_s  = 1'b0;
            end
        endcase
    end

`ifdef SCHED_OVF_EN
    // Extended-width adder so the carry out of the MSB is observable
    always_comb begin
        sum_ext_s = {1'b0, ra_q} + {1'b0, op_b_s} + {{DATAWIDTH{1'b0}}, cin_s};
        sum_s     = sum_ext_s[DATAWIDTH-1:0];
        carry_s   = sum_ext_s[DATAWIDTH];
    end
`else
    // Plain modulo adder; carry is never needed without the overflow flag
    always_comb begin
        sum_s = ra_q + op_b_s + {{(DATAWIDTH-1){1'b0}}, cin_s};
    end
`endif

    // Single unsigned comparator on the two sums
    always_comb begin
        cmp_lt_s = (d_q < e_q);
        cmp_eq_s = (d_q == e_q);
    end

    // Next-state and datapath register update selection
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        d_d     = d_q;
        e_d     = e_q;
        f_d     = f_q;
        g_d     = g_q;
        h_d     = h_q;
        dlte_d  = dlte_q;
        deq_d   = deq_q;
        x_d     = x_q;
        z_d     = z_q;
`ifdef SCHED_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                // Start is only honoured here; DONE->ADD_AB gives back-to-back ops
                if (start) begin
                    state_d = S_ADD_AB;
                    ra_d    = a;
                    rb_d    = b;
                    rc_d    = c;
`ifdef SCHED_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADD_AB: begin
                d_d     = sum_s;
`ifdef SCHED_OVF_EN
                ovf_d   = ovf_q | carry_s;
`endif
                state_d = S_ADD_AC;
            end
            S_ADD_AC: begin
                e_d     = sum_s;
`ifdef SCHED_OVF_EN
                ovf_d   = ovf_q | carry_s;
`endif
                state_d = S_SUB_AB;
            end
            S_SUB_AB: begin
                f_d     = sum_s;
`ifdef SCHED_OVF_EN
                // ra + ~rb + 1 carries out exactly when no borrow occurs
                ovf_d   = ovf_q | ~carry_s;
`endif
                state_d = S_CMP_SEL;
            end
            S_CMP_SEL: begin
                dlte_d  = cmp_lt_s;
                deq_d   = cmp_eq_s;
                g_d     = cmp_lt_s ? e_q : d_q;
                h_d     = cmp_eq_s ? f_q : (cmp_lt_s ? e_q : d_q);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                x_d     = g_q << dlte_q;
                z_d     = h_q >> deq_q;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ADD_AB) || (state_d == S_ADD_AC) ||
                 (state_d == S_SUB_AB) || (state_d == S_CMP_SEL) ||
                 (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    // State, operand, intermediate and output registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            ra_q    <= {DATAWIDTH{1'b0}};
            rb_q    <= {DATAWIDTH{1'b0}};
            rc_q    <= {DATAWIDTH{1'b0}};
            d_q     <= {DATAWIDTH{1'b0}};
            e_q     <= {DATAWIDTH{1'b0}};
            f_q     <= {DATAWIDTH{1'b0}};
            g_q     <= {DATAWIDTH{1'b0}};
            h_q     <= {DATAWIDTH{1'b0}};
            dlte_q  <= 1'b0;
            deq_q   <= 1'b0;
            x_q     <= {DATAWIDTH{1'b0}};
            z_q     <= {DATAWIDTH{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SCHED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            d_q     <= d_d;
            e_q     <= e_d;
            f_q     <= f_d;
            g_q     <= g_d;
            h_q     <= h_d;
            dlte_q  <= dlte_d;
            deq_q   <= deq_d;
            x_q     <= x_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SCHED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign x    = x_q;
    assign z    = z_q;
`ifdef SCHED_OVF_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule
